// File: rtl/convol_core.sv
// convol_core: streaming FIR convolution engine; capture, multiply and accumulate stages
// give a two-edge latency from accepted sample to result.
module convol_core #(
    parameter int DATA_SIZE   = 16,
    parameter int WINDOW_SIZE = 8,
    parameter int FULL_SIZE   = 2*DATA_SIZE+$clog2(WINDOW_SIZE)+1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] input_data,
    input  logic [DATA_SIZE-1:0]        coeff [WINDOW_SIZE],
    input  logic                        enable,
    output logic signed [FULL_SIZE-1:0] output_data,
    output logic                        output_data_valid
);
    localparam int PW = 2*DATA_SIZE+1;
    localparam int CW = $clog2(WINDOW_SIZE)+1;

    typedef enum logic {WARMUP, RUN} state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_fill;
    logic signed [DATA_SIZE-1:0] r_window [WINDOW_SIZE];
    logic [DATA_SIZE-1:0]        r_coeff [WINDOW_SIZE];
    logic signed [PW-1:0]        r_prod [WINDOW_SIZE];
    logic                        r_v0;
    logic                        r_v1;
    logic                        w_last;
    logic signed [FULL_SIZE-1:0] w_sum;

    assign w_last = r_fill == CW'(WINDOW_SIZE-1);

    // Eligibility is tagged at capture so a warm-up sample never inherits RUN from a later one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WARMUP;
            r_fill  <= '0;
            r_v0    <= 1'b0;
        end else begin
            r_v0 <= enable && (r_state == RUN || w_last);
            if (enable && r_state == WARMUP) begin
                r_fill <= r_fill + CW'(1);
                if (w_last)
                    r_state <= RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                r_window[i] <= '0;
                r_coeff[i]  <= '0;
            end
        end else if (enable) begin
            r_window[0] <= input_data;
            for (int i = 1; i < WINDOW_SIZE; i++)
                r_window[i] <= r_window[i-1];
            for (int i = 0; i < WINDOW_SIZE; i++)
                r_coeff[i] <= coeff[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WINDOW_SIZE; i++)
                r_prod[i] <= '0;
            r_v1 <= 1'b0;
        end else begin
            for (int i = 0; i < WINDOW_SIZE; i++)
                r_prod[i] <= PW'(r_window[i]) * PW'($signed({1'b0, r_coeff[i]}));
            r_v1 <= r_v0;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WINDOW_SIZE; i++)
            w_sum = w_sum + FULL_SIZE'(r_prod[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            output_data       <= '0;
            output_data_valid <= 1'b0;
        end else begin
            output_data_valid <= r_v1;
            if (r_v1)
                output_data <= w_sum;
        end
    end
endmodule
